// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Constants shared by the UART receive controller and the UART TX FSM.
//   - RX FSM state encodings (IDLE, START, DATA, PARITY, STOP)
//   - parity type constants (PAR_EVEN / PAR_ODD)
//   - TX output mux-select constants
//   - majority3(): 2-of-3 vote, used when UART_RX_MAJORITY_EN is defined
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t IDLE   = 3'd0;
  localparam rx_state_t START  = 3'd1;
  localparam rx_state_t DATA   = 3'd2;
  localparam rx_state_t PARITY = 3'd3;
  localparam rx_state_t STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // TX serial output mux selects (shared with the TX FSM)
  localparam logic [1:0] TX_MUX_START = 2'b00;
  localparam logic [1:0] TX_MUX_STOP  = 2'b01;
  localparam logic [1:0] TX_MUX_SER   = 2'b10;
  localparam logic [1:0] TX_MUX_PAR   = 2'b11;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
// Per-bit oversampling counter and sample flops for the UART receiver.
// Optional feature macro: UART_RX_MAJORITY_EN (3-sample majority vote).
// Ports:
//   i_clk       in  oversampling clock
//   i_rst_n     in  async active-low reset
//   i_rx        in  synchronised serial line
//   i_active    in  receiver is inside a frame (state != IDLE)
//   i_start     in  start edge seen this cycle (IDLE and line low)
//   i_prescale  in  oversample ratio latched for the current frame
//   o_bit       out decision bit of the current bit period
//   o_bit_end   out high on the last edge (Prescale-1) of each bit period
// ---------------------------------------------------------------------------
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_rx,
  input  logic                      i_active,
  input  logic                      i_start,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  output logic                      o_bit,
  output logic                      o_bit_end
);

  logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
  logic [PRESCALE_WIDTH-1:0] w_last;
  logic [PRESCALE_WIDTH-1:0] w_mid;
  logic                      w_wrap;

  assign w_last    = i_prescale - {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
  assign w_mid     = i_prescale >> 1;
  assign w_wrap    = (r_edge_cnt == w_last);
  assign o_bit_end = i_active & w_wrap;

  // Edge counter: the start-detect cycle is edge 0, so the count moves to 1
  // on the following cycle; outside a frame it rests at 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_edge_cnt <= {PRESCALE_WIDTH{1'b0}};
    end else if (i_active || i_start) begin
      r_edge_cnt <= w_wrap ? {PRESCALE_WIDTH{1'b0}}
                           : r_edge_cnt + {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r_edge_cnt <= {PRESCALE_WIDTH{1'b0}};
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic r_s_lo;
  logic r_s_mid;
  logic r_s_hi;

  // Capture the three samples around the bit centre
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s_lo  <= 1'b1;
      r_s_mid <= 1'b1;
      r_s_hi  <= 1'b1;
    end else if (i_active) begin
      if (r_edge_cnt == (w_mid - {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1})) r_s_lo  <= i_rx;
      if (r_edge_cnt == w_mid)                                        r_s_mid <= i_rx;
      if (r_edge_cnt == (w_mid + {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1})) r_s_hi  <= i_rx;
    end
  end

  assign o_bit = majority3(r_s_lo, r_s_mid, r_s_hi);
`else
  logic r_s_mid;

  // Capture the single centre sample
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s_mid <= 1'b1;
    end else if (i_active && (r_edge_cnt == w_mid)) begin
      r_s_mid <= i_rx;
    end
  end

  assign o_bit = r_s_mid;
`endif

endmodule

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
// UART receive controller: start detect, LSB-first deserialisation, optional
// parity check and stop-bit check. All outputs are registered.
// Optional feature macro: UART_RX_MAJORITY_EN (passed through to the sampler).
// Ports:
//   CLK         in  oversampling clock
//   rst         in  async active-low reset
//   RX_IN       in  synchronised serial line, idles high
//   PAR_EN      in  parity bit present (latched at start edge)
//   PAR_TYP     in  0 even / 1 odd (latched at start edge)
//   Prescale    in  oversample ratio 8/16/32 (latched at start edge)
//   P_DATA      out data of the last good frame
//   data_valid  out 1-cycle strobe, P_DATA updated
//   par_err     out 1-cycle strobe, parity mismatch
//   stp_err     out 1-cycle strobe, stop bit sampled 0
// ---------------------------------------------------------------------------
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_t                 r_state;
  rx_state_t                 w_next_state;
  logic [BW-1:0]             r_bit_cnt;
  logic [DATA_WIDTH-1:0]     r_shift;
  logic                      r_par_en;
  logic                      r_par_typ;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic                      r_par_bad;
  logic                      w_start;
  logic                      w_active;
  logic                      w_bit;
  logic                      w_bit_end;
  logic                      w_last_data;
  logic                      w_valid_nxt;
  logic                      w_par_err_nxt;
  logic                      w_stp_err_nxt;

  function automatic logic expected_parity(input logic [DATA_WIDTH-1:0] d, input logic typ);
    return (typ == PAR_ODD) ? ~^d : ^d;
  endfunction

  assign w_start     = (r_state == IDLE) && !RX_IN;
  assign w_active    = (r_state != IDLE);
  assign w_last_data = (r_bit_cnt == BW'(DATA_WIDTH - 1));

  uart_rx_sampler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_sampler (
    .i_clk      (CLK),
    .i_rst_n    (rst),
    .i_rx       (RX_IN),
    .i_active   (w_active),
    .i_start    (w_start),
    .i_prescale (r_prescale),
    .o_bit      (w_bit),
    .o_bit_end  (w_bit_end)
  );

  // FSM state register
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic; transitions happen only at bit decisions
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:   if (!RX_IN) w_next_state = START; else w_next_state = IDLE;
      START:  if (w_bit_end) w_next_state = w_bit ? IDLE : DATA; else w_next_state = START;
      DATA:   if (w_bit_end && w_last_data) w_next_state = r_par_en ? PARITY : STOP;
              else w_next_state = DATA;
      PARITY: if (w_bit_end) w_next_state = STOP; else w_next_state = PARITY;
      STOP:   if (w_bit_end) w_next_state = IDLE; else w_next_state = STOP;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM output logic: frame verdict at the stop-bit decision
  always_comb begin
    w_valid_nxt   = 1'b0;
    w_par_err_nxt = 1'b0;
    w_stp_err_nxt = 1'b0;
    if ((r_state == STOP) && w_bit_end) begin
      w_valid_nxt   = w_bit & ~r_par_bad;
      w_par_err_nxt = r_par_bad;
      w_stp_err_nxt = ~w_bit;
    end else begin
      w_valid_nxt   = 1'b0;
    end
  end

  // Frame datapath: config latch, bit counter, shift register, parity verdict
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_par_en   <= 1'b0;
      r_par_typ  <= PAR_EVEN;
      r_prescale <= {PRESCALE_WIDTH{1'b0}};
      r_bit_cnt  <= {BW{1'b0}};
      r_shift    <= {DATA_WIDTH{1'b0}};
      r_par_bad  <= 1'b0;
    end else begin
      if (w_start) begin
        r_par_en   <= PAR_EN;
        r_par_typ  <= PAR_TYP;
        r_prescale <= Prescale;
        r_par_bad  <= 1'b0;
      end
      if (w_bit_end) begin
        case (r_state)
          START:  r_bit_cnt <= {BW{1'b0}};
          DATA: begin
            r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
            if (!w_last_data) r_bit_cnt <= r_bit_cnt + {{(BW-1){1'b0}}, 1'b1};
          end
          PARITY: r_par_bad <= (w_bit != expected_parity(r_shift, r_par_typ));
          default: r_bit_cnt <= r_bit_cnt;
        endcase
      end
    end
  end

  // Registered outputs; P_DATA only changes on a good frame
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      P_DATA     <= {DATA_WIDTH{1'b0}};
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= w_valid_nxt;
      par_err    <= w_par_err_nxt;
      stp_err    <= w_stp_err_nxt;
      if (w_valid_nxt) P_DATA <= r_shift;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Directed testbench for uart_rx_ctrl. Frames are driven cycle-accurately;
// cycle 0 of a frame is the first cycle RX_IN is low. A negedge monitor
// counts strobes and records the cycle in which they appear.
// Honours UART_RX_MAJORITY_EN for the spike test expectation.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       rst;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int cyc = 0;
  int n_valid = 0, n_par = 0, n_stp = 0;
  int last_valid_cyc = 0, prev_valid_cyc = 0, last_stp_cyc = 0;
  int frame_start = 0;
  int n_cmp = 0, n_err = 0;
  int bv, bp, bs, t0;

  uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK        (CLK),
    .rst        (rst),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 CLK = ~CLK;

  // Free-running cycle counter
  always @(posedge CLK) cyc <= cyc + 1;

  // Strobe monitor, sampled mid-cycle
  always @(negedge CLK) begin
    if (data_valid) begin
      n_valid        <= n_valid + 1;
      prev_valid_cyc <= last_valid_cyc;
      last_valid_cyc <= cyc;
    end
    if (par_err) n_par <= n_par + 1;
    if (stp_err) begin
      n_stp        <= n_stp + 1;
      last_stp_cyc <= cyc;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic snap();
    bv = n_valid;
    bp = n_par;
    bs = n_stp;
  endtask

  // Drive one frame; spike = frame-bit index (1 = data bit 0) that gets a
  // 1-cycle high pulse at edge Prescale/2, or -1 for none.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pbit,
                            input logic stopb, input int spike);
    logic [11:0] bits;
    int nb;
    bits = 12'h000;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    nb = 9;
    if (pe) begin
      bits[nb] = pbit;
      nb++;
    end
    bits[nb] = stopb;
    nb++;
    frame_start = cyc;
    for (int b = 0; b < nb; b++) begin
      for (int e = 0; e < int'(Prescale); e++) begin
        RX_IN = (b == spike && e == int'(Prescale) / 2) ? 1'b1 : bits[b];
        @(posedge CLK);
        #1;
      end
    end
    RX_IN = 1'b1;
  endtask

  initial begin
    rst      = 1'b0;
    RX_IN    = 1'b1;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    Prescale = 6'd8;
    #23;
    check_val("rst_pdata", {24'h0, P_DATA}, 32'h0);
    check_val("rst_valid", {31'h0, data_valid}, 32'h0);
    check_val("rst_parerr", {31'h0, par_err}, 32'h0);
    check_val("rst_stperr", {31'h0, stp_err}, 32'h0);
    @(posedge CLK);
    #1;
    rst = 1'b1;
    idle(4);

    // T1: 8N1, Prescale 8, 0xA5
    snap();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1);
    idle(2);
    check_val("t1_nvalid", n_valid - bv, 32'd1);
    check_val("t1_latency", last_valid_cyc - frame_start, 32'd80);
    check_val("t1_pdata", {24'h0, P_DATA}, 32'hA5);
    check_val("t1_errs", (n_par - bp) + (n_stp - bs), 32'd0);

    // T2: Prescale 16, even parity, 0x3C good then bad parity
    Prescale = 6'd16;
    PAR_EN   = 1'b1;
    PAR_TYP  = 1'b0;
    snap();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1);
    idle(2);
    check_val("t2_nvalid", n_valid - bv, 32'd1);
    check_val("t2_latency", last_valid_cyc - frame_start, 32'd176);
    check_val("t2_pdata", {24'h0, P_DATA}, 32'h3C);
    snap();
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1);
    idle(2);
    check_val("t2b_parerr", n_par - bp, 32'd1);
    check_val("t2b_nvalid", n_valid - bv, 32'd0);
    check_val("t2b_stperr", n_stp - bs, 32'd0);
    check_val("t2b_pdata", {24'h0, P_DATA}, 32'h3C);

    // T3: 8N1, stop bit 0
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    snap();
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1);
    idle(2);
    check_val("t3_stperr", n_stp - bs, 32'd1);
    check_val("t3_latency", last_stp_cyc - frame_start, 32'd80);
    check_val("t3_nvalid", n_valid - bv, 32'd0);
    check_val("t3_parerr", n_par - bp, 32'd0);

    // T4: 2-cycle glitch, then a good frame
    snap();
    RX_IN = 1'b0;
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
    idle(16);
    check_val("t4_glitch", (n_valid - bv) + (n_par - bp) + (n_stp - bs), 32'd0);
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, -1);
    idle(2);
    check_val("t4_nvalid", n_valid - bv, 32'd1);
    check_val("t4_pdata", {24'h0, P_DATA}, 32'h96);

    // T5: Prescale 32, back-to-back 0x01, 0xFF
    Prescale = 6'd32;
    snap();
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, -1);
    t0 = frame_start;
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, -1);
    idle(2);
    check_val("t5_nvalid", n_valid - bv, 32'd2);
    check_val("t5_gap", last_valid_cyc - prev_valid_cyc, 32'd320);
    check_val("t5_first", prev_valid_cyc - t0, 32'd320);
    check_val("t5_pdata", {24'h0, P_DATA}, 32'hFF);

    // T6: reset mid-DATA, then 0x5A
    Prescale = 6'd8;
    RX_IN = 1'b0;
    repeat (20) begin
      @(posedge CLK);
      #1;
    end
    #2;
    rst = 1'b0;
    #1;
    check_val("t6_pdata", {24'h0, P_DATA}, 32'h0);
    check_val("t6_strobes", {29'h0, data_valid, par_err, stp_err}, 32'h0);
    RX_IN = 1'b1;
    @(posedge CLK);
    #1;
    rst = 1'b1;
    idle(4);
    snap();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, -1);
    idle(2);
    check_val("t6_nvalid", n_valid - bv, 32'd1);
    check_val("t6_rx", {24'h0, P_DATA}, 32'h5A);

    // T7: spike at the centre of data bit 0 of a 0x00 frame
    snap();
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1);
    idle(2);
    check_val("t7_nvalid", n_valid - bv, 32'd1);
`ifdef UART_RX_MAJORITY_EN
    check_val("t7_spike", {24'h0, P_DATA}, 32'h00);
`else
    check_val("t7_spike", {24'h0, P_DATA}, 32'h01);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
